// File: rtl/mac_pipe_acc.sv
// mac_pipe_acc: three-stage pipelined multiply-accumulate.
//   S1 registers the operands and framing bits, S2 forms the full 2*WIDTH product,
//   and S3 adds the product to the accumulator (or loads it on a first term).
//   Signed or unsigned operands, with saturating or wrapping accumulation.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid          qualifies a, b, first and last in this cycle
//   first / last      start / end of a dot product
//   a, b              WIDTH-bit operands
//   acc_val           accumulator register, always visible
//   out_valid         one-cycle strobe: acc_val holds a completed accumulation
//   ovf               sticky overflow flag for the current accumulation
module mac_pipe_acc #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned GUARD    = 4,
  parameter int unsigned ACC_W    = 2 * WIDTH + GUARD,
  parameter bit          SIGNED   = 1'b0,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             first,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [ACC_W-1:0] acc_val,
  output logic             out_valid,
  output logic             ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  if (ACC_W < PW) begin : g_bad_acc_w
    $error("mac_pipe_acc: ACC_W (%0d) must be >= 2*WIDTH (%0d)", ACC_W, PW);
  end

  // S1
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic             vld1_q, vld1_d, first1_q, first1_d, last1_q, last1_d;
  // S2
  logic [PW-1:0]    p2_q, p2_d;
  logic             vld2_q, vld2_d, first2_q, first2_d, last2_q, last2_d;
  // S3
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d, ovf_q, ovf_d;

  logic [PW-1:0]    a_ext, b_ext;
  logic [ACC_W-1:0] p_ext, sat_val;
  logic [ACC_W:0]   sum;
  logic             ov;

  always_comb begin
    a1_d     = a;
    b1_d     = b;
    vld1_d   = in_valid;
    first1_d = first;
    last1_d  = last;

    // Low 2*WIDTH bits of the product of the extended operands equal the
    // signed (or unsigned) product; extension keeps the multiply width-clean.
    a_ext = {{WIDTH{SIGNED & a1_q[WIDTH-1]}}, a1_q};
    b_ext = {{WIDTH{SIGNED & b1_q[WIDTH-1]}}, b1_q};
    p2_d     = a_ext * b_ext;
    vld2_d   = vld1_q;
    first2_d = first1_q;
    last2_d  = last1_q;

    // Fill first then overlay the product, so GUARD=0 needs no zero-width replication.
    p_ext = (SIGNED && p2_q[PW-1]) ? '1 : '0;
    p_ext[PW-1:0] = p2_q;

    sum = {1'b0, acc_q} + {1'b0, p_ext};
    if (SIGNED) begin
      ov = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      ov = sum[ACC_W];
    end

    // Signed clamp direction follows the common operand sign.
    if (!SIGNED) begin
      sat_val = '1;
    end else if (!acc_q[ACC_W-1]) begin
      sat_val = '1;
      sat_val[ACC_W-1] = 1'b0;
    end else begin
      sat_val = '0;
      sat_val[ACC_W-1] = 1'b1;
    end

    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    if (vld2_q) begin
      out_valid_d = last2_q;
      if (first2_q) begin
        acc_d = p_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum[ACC_W-1:0];
        if (ov) begin
          ovf_d = 1'b1;
          if (SATURATE) acc_d = sat_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a1_q        <= '0;
      b1_q        <= '0;
      vld1_q      <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      p2_q        <= '0;
      vld2_q      <= 1'b0;
      first2_q    <= 1'b0;
      last2_q     <= 1'b0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      a1_q        <= a1_d;
      b1_q        <= b1_d;
      vld1_q      <= vld1_d;
      first1_q    <= first1_d;
      last1_q     <= last1_d;
      p2_q        <= p2_d;
      vld2_q      <= vld2_d;
      first2_q    <= first2_d;
      last2_q     <= last2_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign acc_val   = acc_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/mac_pipe_acc.md
Name: mac_pipe_acc

Overview:
Parametrised, pipelined multiply-accumulate unit. It is the successor to the fixed 8x8 MAC: configurable operand width and accumulator guard bits, signed or unsigned mode, and saturating or wrapping accumulation. Framing inputs mark the first and last term of a dot product, and the block emits a one-cycle result-valid strobe. It sits between operand sources (sample/coefficient buffers) and the result consumer in the datapath.

Parameters:
WIDTH, 8, operand width of a and b (bits).
GUARD, 4, accumulator guard bits above the full product width.
ACC_W, 2*WIDTH+GUARD, accumulator/result width (derived; must be >= 2*WIDTH).
SIGNED, 0, 0 = unsigned operands/accumulator; 1 = two's-complement.
SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, synchronous, active-high.
in_valid  in  1  a/b/first/last qualify this cycle.
first  in  1  this term starts a new accumulation (replaces accumulator).
last  in  1  this term ends the accumulation (raises out_valid).
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
acc_val  out  ACC_W  accumulator register, always visible.
out_valid  out  1  one-cycle strobe: acc_val holds a completed accumulation.
ovf  out  1  sticky overflow flag for the current accumulation.

Behaviour:
- Reset, synchronous, active-high: on a rising edge with rst=1, clear the S1/S2 valid bits, acc_val=0, out_valid=0, ovf=0. Inputs presented in that cycle are discarded. Reset mid-stream drops all in-flight terms; no out_valid follows.
- Pipeline is free-running, with no stall or backpressure. Each stage forwards a valid bit. When in_valid=0, first and last are ignored and a bubble propagates; a bubble leaves acc_val, ovf and out_valid (=0) unchanged.
- S1, edge 1: register a, b, first, last and in_valid.
- S2, edge 2: p = a1*b1, full 2*WIDTH product. Signed multiply if SIGNED=1, else unsigned. Register p, first, last and valid.
- S3, edge 3, when the S2 valid bit is set:
  - first2=1: acc_val = ext(p), sign-extended if SIGNED else zero-extended; ovf=0.
  - first2=0: sum = acc_val + ext(p), computed at ACC_W+1 bits.
  - Unsigned overflow: carry out. Signed overflow: the operands have the same sign and the sum sign differs.
  - On overflow with SATURATE=1: clamp to 2^ACC_W-1 (unsigned), or to max positive / min negative by the sign of the operands (signed).
  - On overflow with SATURATE=0: keep the low ACC_W bits.
  - Any overflow sets ovf. ovf stays set until the next first term or reset.
  - out_valid = last2 (registered with the acc update). When S2 holds a bubble, out_valid=0.
- Latency: a term presented in cycle n with in_valid=1 is reflected in acc_val, and in out_valid if last, after the 3rd rising edge (visible in cycle n+3). Throughput is one term per clock.
- first=1 and last=1 on the same term: acc_val = product, out_valid pulses.
- A term without a preceding first adds to the existing acc_val. After reset this is 0, so the first term after reset behaves as first.
- A new first immediately after a last (back-to-back dot products) is supported with no idle cycle.
- ACC_W < 2*WIDTH is illegal; simulation must flag it with an elaboration-time check.

Test Plan:
1. Unsigned, WIDTH=8, SIGNED=0: terms (3,4,first), (5,6), (7,8,last) in consecutive cycles from cycle 0 -> acc_val=12 in cycle 3, 42 in cycle 4, 98 in cycle 5; out_valid=1 only in cycle 5; ovf=0.
2. Signed, SIGNED=1: (-128,-128,first), (-3,5,last) -> 16384, then 16369; out_valid with 16369; ovf=0.
3. Saturation, GUARD=0 (ACC_W=16), unsigned: (255,255,first), (255,255,last) -> 65025, then clamped 65535 with ovf=1. Next term (2,2,first,last) -> acc_val=4, ovf=0. Repeat with SATURATE=0 -> 64514, ovf=1.
4. Bubbles: sequence (1,1,first), idle, idle, (2,2), idle, (3,3,last), with first/last toggled during idle cycles -> final acc_val=14; exactly one out_valid; acc_val unchanged across bubbles.
5. Back-to-back and single-term: (4,4,first,last), then (5,5,first,last) next cycle -> out_valid in two consecutive cycles with 16, then 25.
6. Reset mid-operation: start (9,9,first), (9,9); assert rst the next cycle for 1 cycle -> acc_val=0, out_valid=0, ovf=0 after the reset edge; no late updates from dropped terms. A post-reset (2,3,last) gives 6.
